pcm_mem_arbiter: RTL

Parametrised N-port arbiter granting the PCM CPU array access to the single-port on-chip PCM memory. Generalises the fixed four-CPU memory hookup to N_CPU ports with selectable fixed-priority or round-robin arbitration, configurable memory read latency, byte enables, and out-of-range address detection. Sits between the CPU instances and the PCM memory slave that the Nios host also addresses.

---
 rtl/pcm_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/pcm_mem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pcm_arb_pkg.sv
// Shared types and helpers for the PCM memory arbiter.
// Holds the FSM state encoding, arbitration mode constants and the index-width helper.
package pcm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of an encoded port index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request picker: first requester at or after the pointer wins.
// Fixed-priority mode forces the pointer to zero so port 0 is always preferred.
module rr_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          fixed_mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] ptr_eff_s;
  logic [IW-1:0] cand_s;
  int            base_s;
  logic          found_s;
  logic          hit_s;

  // Walk the ports in priority order starting at the effective pointer.
  always_comb begin
    ptr_eff_s = fixed_mode ? '0 : ptr;
    base_s    = int'(ptr_eff_s);
    cand_s    = '0;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand_s        = IW'((base_s + k) % N);
      hit_s         = req[cand_s] & ~found_s;
      grant[cand_s] = hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      found_s       = found_s | hit_s;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pcm_mem_arbiter.sv
// N-port arbiter in front of the single-port PCM memory: one transaction in flight,
// fixed-priority or round-robin grant, configurable read latency and range checking.
module pcm_mem_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int N_CPU    = 4,
  parameter int CPU_AW   = 20,
  parameter int MEM_AW   = 11,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_CPU-1:0]             cpu_req,
  input  logic [N_CPU-1:0]             cpu_we,
  input  logic [N_CPU-1:0][CPU_AW-1:0] cpu_addr,
  input  logic [N_CPU-1:0][DW-1:0]     cpu_wdata,
  input  logic [N_CPU-1:0][DW/8-1:0]   cpu_be,
  output logic [N_CPU-1:0]             cpu_ready,
  output logic [N_CPU-1:0][DW-1:0]     cpu_rdata,
  output logic [N_CPU-1:0]             cpu_err,
  output logic [MEM_AW-1:0]            mem_address,
  output logic                         mem_chipselect,
  output logic                         mem_clken,
  output logic                         mem_write,
  output logic [DW-1:0]                mem_writedata,
  output logic [DW/8-1:0]              mem_byteenable,
  input  logic [DW-1:0]                mem_readdata,
  output logic                         busy
);

  localparam int              IW         = idx_w(N_CPU);
  localparam int              BW         = DW / 8;
  localparam int              CW         = 2;
  localparam logic            RD_WAIT    = (RD_LAT > 1);
  localparam logic [CW-1:0]   WAIT_INIT  = (RD_LAT > 1) ? CW'(RD_LAT - 2) : '0;
  localparam logic            FIXED_MODE = (ARB_MODE == ARB_FIXED);

  // Any address bit above the memory window marks the access out of range.
  function automatic logic addr_oor(input logic [CPU_AW-1:0] a);
    return |a[CPU_AW-1:MEM_AW];
  endfunction

  arb_state_e               state_r;
  arb_state_e               state_s;
  logic [IW-1:0]            ptr_r;
  logic [IW-1:0]            ptr_nxt_s;
  logic [IW-1:0]            gnt_r;
  logic [IW-1:0]            gidx_s;
  logic [N_CPU-1:0]         gnt_oh_r;
  logic [N_CPU-1:0]         arb_oh_s;
  logic                     any_req_s;
  logic                     we_r;
  logic                     err_r;
  logic [CW-1:0]            wait_cnt_r;
  logic                     grant_s;
  logic                     oor_s;
  logic                     strobe_s;
  logic                     wr_s;
  logic                     resp_s;
  logic                     rd_resp_s;
  logic [DW-1:0]            rd_data_s;
  logic [N_CPU-1:0]         ready_s;
  logic [N_CPU-1:0]         err_vec_s;
  logic [MEM_AW-1:0]        mem_address_r;
  logic                     mem_chipselect_r;
  logic                     mem_clken_r;
  logic                     mem_write_r;
  logic [DW-1:0]            mem_writedata_r;
  logic [BW-1:0]            mem_byteenable_r;
  logic [N_CPU-1:0]         cpu_ready_r;
  logic [N_CPU-1:0]         cpu_err_r;
  logic [N_CPU-1:0][DW-1:0] rdata_r;
  logic                     busy_r;

  rr_arbiter #(
    .N  (N_CPU),
    .IW (IW)
  ) u_arb (
    .req        (cpu_req),
    .ptr        (ptr_r),
    .fixed_mode (FIXED_MODE),
    .grant      (arb_oh_s),
    .grant_idx  (gidx_s),
    .any_req    (any_req_s)
  );

  assign ptr_nxt_s = (gidx_s == IW'(N_CPU - 1)) ? '0 : gidx_s + IW'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; only in-range reads with extra latency pass through WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_s = ISSUE;
        else           state_s = IDLE;
      end
      ISSUE: begin
        if (!we_r && !err_r && RD_WAIT) state_s = WAIT;
        else                            state_s = RESP;
      end
      WAIT: begin
        if (wait_cnt_r == '0) state_s = RESP;
        else                  state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode, computed one cycle ahead so every strobe leaves a flop.
  always_comb begin
    grant_s   = (state_r == IDLE) && any_req_s;
    oor_s     = addr_oor(cpu_addr[gidx_s]);
    strobe_s  = grant_s && !oor_s;
    wr_s      = strobe_s && cpu_we[gidx_s];
    resp_s    = (state_s == RESP);
    ready_s   = resp_s ? gnt_oh_r : '0;
    err_vec_s = (resp_s && err_r) ? gnt_oh_r : '0;
    rd_resp_s = (state_r == RESP) && !we_r;
    rd_data_s = err_r ? '0 : mem_readdata;
  end

  // Grant capture, memory strobes and response pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r            <= '0;
      gnt_r            <= '0;
      gnt_oh_r         <= '0;
      we_r             <= 1'b0;
      err_r            <= 1'b0;
      wait_cnt_r       <= '0;
      mem_address_r    <= '0;
      mem_chipselect_r <= 1'b0;
      mem_clken_r      <= 1'b0;
      mem_write_r      <= 1'b0;
      mem_writedata_r  <= '0;
      mem_byteenable_r <= '0;
      cpu_ready_r      <= '0;
      cpu_err_r        <= '0;
      busy_r           <= 1'b0;
    end else begin
      mem_chipselect_r <= strobe_s;
      mem_clken_r      <= strobe_s;
      mem_write_r      <= wr_s;
      cpu_ready_r      <= ready_s;
      cpu_err_r        <= err_vec_s;
      busy_r           <= (state_s != IDLE);
      if (grant_s) begin
        gnt_r    <= gidx_s;
        gnt_oh_r <= arb_oh_s;
        ptr_r    <= ptr_nxt_s;
        we_r     <= cpu_we[gidx_s];
        err_r    <= oor_s;
      end
      if (strobe_s) begin
        mem_address_r    <= cpu_addr[gidx_s][MEM_AW-1:0];
        mem_writedata_r  <= cpu_wdata[gidx_s];
        mem_byteenable_r <= cpu_be[gidx_s];
      end
      if (state_r == ISSUE) begin
        wait_cnt_r <= WAIT_INIT;
      end else if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r - CW'(1);
      end
    end
  end

  // Per-port read data holding register, refreshed at the end of each read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= '0;
    end else if (rd_resp_s) begin
      rdata_r[gnt_r] <= rd_data_s;
    end
  end

  // During a read response the granted port sees the memory word alongside its ready pulse.
  always_comb begin
    cpu_rdata = rdata_r;
    if (rd_resp_s) begin
      cpu_rdata[gnt_r] = rd_data_s;
    end else begin
      cpu_rdata = rdata_r;
    end
  end

  assign mem_address    = mem_address_r;
  assign mem_chipselect = mem_chipselect_r;
  assign mem_clken      = mem_clken_r;
  assign mem_write      = mem_write_r;
  assign mem_writedata  = mem_writedata_r;
  assign mem_byteenable = mem_byteenable_r;
  assign cpu_ready      = cpu_ready_r;
  assign cpu_err        = cpu_err_r;
  assign busy           = busy_r;

endmodule
